// File: rtl/hsd_accumulator.sv
// hsd_accumulator
//   Hybrid signed-digit accumulator. The running sum is held redundantly as
//   (acc_p - acc_n) mod 2^W, so every add/subtract beat is one row of per-bit
//   full-adder cells. There is no W-bit carry chain in the accumulate path.
//   A conv_req starts a chunked borrow-subtract FSM. The FSM turns a snapshot
//   of the redundant sum back into binary, CHUNK bits per clock, LSB first.
//
//   Optional build macro: HSD_INPUT_REG_EN
//     Defined   : in_valid/in_sub/in_data are registered ahead of the HSD add
//                 stage, so a beat takes 2 edges to reach acc_p/acc_n. A SNAP
//                 state delays the snapshot by one cycle so that it includes
//                 any beat still in the input register.
//     Undefined : single-stage add.
//
// Parameters
//   W      accumulator width; all arithmetic is modulo 2^W
//   CHUNK  bits converted per clock; W must be a multiple of CHUNK
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clr          synchronous clear of the sum and FSM; conv_data is kept
//   in_valid     operand beat valid
//   in_ready     beat can be accepted (only in ACC)
//   in_sub       1: subtract in_data, 0: add in_data
//   in_data      W-bit two's-complement operand
//   conv_req     start a redundant-to-binary conversion (ignored while busy)
//   conv_busy    conversion in progress (SNAP/CONV/DONE)
//   conv_valid   one-cycle strobe: conv_data has just been updated
//   conv_data    binary value of the snapshot; held until the next DONE
//   acc_p/acc_n  redundant accumulator, positive and negative parts
module hsd_accumulator #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [W-1:0] in_data,
    input  logic         conv_req,
    output logic         conv_busy,
    output logic         conv_valid,
    output logic [W-1:0] conv_data,
    output logic [W-1:0] acc_p,
    output logic [W-1:0] acc_n
);

    localparam int NCH = W / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if ((CHUNK < 1) || (W <= CHUNK) || ((W % CHUNK) != 0)) begin : g_bad_chunk
            $error("hsd_accumulator: W must be a multiple of CHUNK (and larger than it)");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACC,
`ifdef HSD_INPUT_REG_EN
        SNAP,
`endif
        CONV,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   snap_p, snap_n;
    logic [W-1:0]   conv_work;
    logic           borrow;
    logic [CW-1:0]  chunk_cnt;

    // Operand presented to the HSD add stage
    logic           add_valid;
    logic           add_sub;
    logic [W-1:0]   add_data;

`ifdef HSD_INPUT_REG_EN
    logic           reg_valid;
    logic           reg_sub;
    logic [W-1:0]   reg_data;

    assign add_valid = reg_valid;
    assign add_sub   = reg_sub;
    assign add_data  = reg_data;
`else
    assign add_valid = in_valid && in_ready;
    assign add_sub   = in_sub;
    assign add_data  = in_data;
`endif

    // HSD add stage: one full adder per bit.
    //   add: P + ~N + X = S + 2C  ->  P' = S,        N' = ~(C << 1)
    //   sub: N + ~P + X = S + 2C  ->  N' = S,        P' = ~(C << 1)
    // Both cases keep P' - N' = P - N +/- X (mod 2^W), and the carries only
    // move one bit position. The operand always enters unnegated.
    logic [W-1:0] fa_a, fa_b, fa_s, fa_c;
    logic [W-1:0] acc_p_next, acc_n_next;

    always_comb begin
        fa_a       = add_sub ? acc_n : acc_p;
        fa_b       = add_sub ? ~acc_p : ~acc_n;
        fa_s       = fa_a ^ fa_b ^ add_data;
        fa_c       = (fa_a & fa_b) | (fa_a & add_data) | (fa_b & add_data);
        acc_p_next = acc_p;
        acc_n_next = acc_n;
        if (add_valid) begin
            if (add_sub) begin
                acc_n_next = fa_s;
                acc_p_next = ~(fa_c << 1);
            end else begin
                acc_p_next = fa_s;
                acc_n_next = ~(fa_c << 1);
            end
        end
    end

    // One chunk of snap_p - snap_n - borrow; the top bit is the outgoing borrow
    logic [CHUNK:0] chunk_diff;

    always_comb begin
        chunk_diff = {1'b0, snap_p[CHUNK-1:0]}
                   - {1'b0, snap_n[CHUNK-1:0]}
                   - {{CHUNK{1'b0}}, borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            acc_p      <= '0;
            acc_n      <= '0;
            snap_p     <= '0;
            snap_n     <= '0;
            conv_work  <= '0;
            conv_data  <= '0;
            borrow     <= 1'b0;
            chunk_cnt  <= '0;
            conv_valid <= 1'b0;
            in_ready   <= 1'b1;
            conv_busy  <= 1'b0;
`ifdef HSD_INPUT_REG_EN
            reg_valid  <= 1'b0;
            reg_sub    <= 1'b0;
            reg_data   <= '0;
`endif
        end else if (clr) begin
            state      <= ACC;
            acc_p      <= '0;
            acc_n      <= '0;
            borrow     <= 1'b0;
            chunk_cnt  <= '0;
            conv_valid <= 1'b0;
            in_ready   <= 1'b1;
            conv_busy  <= 1'b0;
`ifdef HSD_INPUT_REG_EN
            reg_valid  <= 1'b0;
`endif
        end else begin
            acc_p      <= acc_p_next;
            acc_n      <= acc_n_next;
            conv_valid <= 1'b0;
`ifdef HSD_INPUT_REG_EN
            reg_valid  <= in_valid && in_ready;
            reg_sub    <= in_sub;
            reg_data   <= in_data;
`endif
            case (state)
                ACC: begin
                    if (conv_req) begin
                        in_ready  <= 1'b0;
                        conv_busy <= 1'b1;
                        borrow    <= 1'b0;
                        chunk_cnt <= '0;
`ifdef HSD_INPUT_REG_EN
                        state     <= SNAP;
`else
                        // Snapshot includes a beat accepted on this same edge
                        snap_p    <= acc_p_next;
                        snap_n    <= acc_n_next;
                        state     <= CONV;
`endif
                    end
                end
`ifdef HSD_INPUT_REG_EN
                SNAP: begin
                    snap_p <= acc_p_next;
                    snap_n <= acc_n_next;
                    state  <= CONV;
                end
`endif
                CONV: begin
                    conv_work <= {chunk_diff[CHUNK-1:0], conv_work[W-1:CHUNK]};
                    snap_p    <= snap_p >> CHUNK;
                    snap_n    <= snap_n >> CHUNK;
                    borrow    <= chunk_diff[CHUNK];
                    chunk_cnt <= chunk_cnt + CW'(1);
                    if (chunk_cnt == CW'(NCH - 1)) begin
                        conv_data  <= {chunk_diff[CHUNK-1:0], conv_work[W-1:CHUNK]};
                        conv_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    conv_busy <= 1'b0;
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    conv_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsd_accumulator.sv
// tb_hsd_accumulator
//   Directed and random checks of hsd_accumulator (W=16, CHUNK=4).
//   Also works when HSD_INPUT_REG_EN is defined for both files.
module tb_hsd_accumulator;

    localparam int NCH = 4;
`ifdef HSD_INPUT_REG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    // Cycle (counted from the edge that samples conv_req) in which conv_valid is high
    localparam int EXP_AT = NCH + XL;

    logic        clk, rst_n, clr, in_valid, in_sub, conv_req;
    logic [15:0] in_data;
    logic        in_ready, conv_busy, conv_valid;
    logic [15:0] conv_data, acc_p, acc_n;
    logic [15:0] dv;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    hsd_accumulator #(.W(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_data   (in_data),
        .conv_req  (conv_req),
        .conv_busy (conv_busy),
        .conv_valid(conv_valid),
        .conv_data (conv_data),
        .acc_p     (acc_p),
        .acc_n     (acc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic beat(input logic sub, input logic [15:0] d);
        in_valid = 1'b1; in_sub = sub; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sub = 1'b0; in_data = '0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Pulses conv_req for one edge and watches conv_valid for 12 cycles afterwards
    task automatic run_conv(output logic [15:0] data, output int nvalid, output int at);
        nvalid = 0; at = -1; data = '0;
        conv_req = 1'b1;
        @(posedge clk); #1;
        conv_req = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (conv_valid) begin nvalid++; at = j; data = conv_data; end
        end
    endtask

    task automatic test_reset();
        logic [15:0] d; int n; int at;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_data = '0; conv_req = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (acc_p !== 16'h0 || acc_n !== 16'h0) $display("FAIL reset_acc: got %h/%h want 0000/0000", acc_p, acc_n); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1 || conv_busy !== 1'b0 || conv_valid !== 1'b0) $display("FAIL reset_ctrl: got rdy=%b busy=%b vld=%b want 1/0/0", in_ready, conv_busy, conv_valid); else pass_cnt++;
        chk_cnt++; if (conv_data !== 16'h0) $display("FAIL reset_conv_data: got %h want 0000", conv_data); else pass_cnt++;
        // Assert reset mid-conversion, away from any clock edge
        beat(1'b0, 16'h0003);
        conv_req = 1'b1;
        @(posedge clk); #1; conv_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_cnt++; if (in_ready !== 1'b0 || conv_busy !== 1'b1) $display("FAIL reset_pre_busy: got rdy=%b busy=%b want 0/1", in_ready, conv_busy); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (acc_p !== 16'h0 || acc_n !== 16'h0) $display("FAIL reset_async_acc: got %h/%h want 0000/0000", acc_p, acc_n); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1 || conv_busy !== 1'b0 || conv_valid !== 1'b0) $display("FAIL reset_async_ctrl: got rdy=%b busy=%b vld=%b want 1/0/0", in_ready, conv_busy, conv_valid); else pass_cnt++;
        #2 rst_n = 1'b1;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (conv_valid) n++;
        end
        chk_cnt++; if (n !== 0) $display("FAIL reset_abort: got %0d conv_valid strobes want 0", n); else pass_cnt++;
        chk_cnt++; if (conv_data !== 16'h0) $display("FAIL reset_abort_data: got %h want 0000", conv_data); else pass_cnt++;
        d = '0; at = 0;
    endtask

    task automatic test_basic();
        logic [15:0] d; int n; int at;
        do_clr();
        beat(1'b0, 16'd4);
        beat(1'b1, 16'd10);
        beat(1'b0, 16'd5);
        run_conv(d, n, at);
        chk_cnt++; if (d !== 16'hFFFF) $display("FAIL basic_data: got %h want FFFF", d); else pass_cnt++;
        chk_cnt++; if (n !== 1) $display("FAIL basic_strobes: got %0d want 1", n); else pass_cnt++;
        chk_cnt++; if (at !== EXP_AT) $display("FAIL basic_latency: got %0d want %0d", at, EXP_AT); else pass_cnt++;
        dv = acc_p - acc_n;
        chk_cnt++; if (dv !== 16'hFFFF) $display("FAIL basic_acc: got %h want FFFF", dv); else pass_cnt++;
        chk_cnt++; if (conv_data !== 16'hFFFF) $display("FAIL basic_hold: got %h want FFFF", conv_data); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [15:0] d; int n; int at;
        do_clr();
        chk_cnt++; if (acc_p !== 16'h0 || acc_n !== 16'h0) $display("FAIL clr_acc: got %h/%h want 0000/0000", acc_p, acc_n); else pass_cnt++;
        beat(1'b0, 16'hFFFF);
        beat(1'b0, 16'h0002);
        run_conv(d, n, at);
        chk_cnt++; if (d !== 16'h0001 || n !== 1) $display("FAIL wrap: got %h (%0d strobes) want 0001 (1)", d, n); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_clr();
        in_valid = 1'b1;
        in_sub = 1'b0; in_data = 16'd1; @(posedge clk); #1;
        in_sub = 1'b0; in_data = 16'd2; @(posedge clk); #1;
        in_sub = 1'b1; in_data = 16'd3; @(posedge clk); #1;
        in_sub = 1'b0; in_data = 16'd4; @(posedge clk); #1;
        in_sub = 1'b0; in_data = 16'd5; @(posedge clk); #1;
        in_valid = 1'b0; in_sub = 1'b0; in_data = '0;
        @(posedge clk); #1;
        dv = acc_p - acc_n;
        chk_cnt++; if (dv !== 16'd9) $display("FAIL back_to_back: got %h want 0009", dv); else pass_cnt++;
    endtask

    task automatic test_same_edge();
        logic [15:0] d, cd; int n; int at; int low; int nv;
        do_clr();
        beat(1'b0, 16'd100);
        // +27 and conv_req on the same edge
        in_valid = 1'b1; in_sub = 1'b0; in_data = 16'd27; conv_req = 1'b1;
        @(posedge clk); #1;
        conv_req = 1'b0; in_data = 16'd26;   // held beat while busy
        low = 0; nv = 0; cd = '0;
        for (int j = 0; j < 20; j++) begin
            if (conv_valid) begin nv++; cd = conv_data; end
            if (in_ready) break;
            low++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        chk_cnt++; if (cd !== 16'h007F || nv !== 1) $display("FAIL same_edge_data: got %h (%0d strobes) want 007F (1)", cd, nv); else pass_cnt++;
        chk_cnt++; if (low !== NCH + 1 + XL) $display("FAIL same_edge_ready_low: got %0d want %0d", low, NCH + 1 + XL); else pass_cnt++;
        run_conv(d, n, at);
        chk_cnt++; if (d !== 16'd153 || n !== 1) $display("FAIL held_beat: got %h (%0d strobes) want 0099 (1)", d, n); else pass_cnt++;
    endtask

    task automatic test_clr_conv();
        logic [15:0] d; int n; int at;
        beat(1'b0, 16'd7);
        conv_req = 1'b1;
        @(posedge clk); #1;
        conv_req = 1'b0;
        for (int j = 0; j < 1 + XL; j++) begin @(posedge clk); #1; end
        do_clr();   // sampled at the end of the 2nd CONV cycle
        chk_cnt++; if (acc_p !== 16'h0 || acc_n !== 16'h0) $display("FAIL clr_conv_acc: got %h/%h want 0000/0000", acc_p, acc_n); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1 || conv_busy !== 1'b0) $display("FAIL clr_conv_ctrl: got rdy=%b busy=%b want 1/0", in_ready, conv_busy); else pass_cnt++;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            if (conv_valid) n++;
            @(posedge clk); #1;
        end
        chk_cnt++; if (n !== 0) $display("FAIL clr_conv_strobe: got %0d want 0", n); else pass_cnt++;
        chk_cnt++; if (conv_data !== 16'd153) $display("FAIL clr_conv_hold: got %h want 0099", conv_data); else pass_cnt++;
        run_conv(d, n, at);
        chk_cnt++; if (d !== 16'h0 || n !== 1) $display("FAIL clr_conv_next: got %h (%0d strobes) want 0000 (1)", d, n); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] msum, delta, pend_d, exp_conv;
        logic        pend_v, snap_pending, acc_now;
        int          busy, accepted, errs;
        msum = '0; pend_d = '0; pend_v = 1'b0; snap_pending = 1'b0; exp_conv = '0;
        busy = 0; accepted = 0; errs = 0;
        do_clr();
        for (int cyc = 0; cyc < 20000 && accepted < 2000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sub   = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            conv_req = ($urandom_range(0, 29) == 0);
            clr      = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
            if (clr) begin
                msum = '0; busy = 0; pend_v = 1'b0; snap_pending = 1'b0;
            end else begin
                acc_now = in_valid && (busy == 0);
                if (acc_now) accepted++;
                delta = in_sub ? (16'h0 - in_data) : in_data;
                if (XL != 0) begin
                    if (pend_v) msum = msum + pend_d;
                    pend_v = acc_now; pend_d = delta;
                end else if (acc_now) begin
                    msum = msum + delta;
                end
                if (snap_pending) begin exp_conv = msum; snap_pending = 1'b0; end
                if (busy == 0 && conv_req) begin
                    busy = NCH + XL + 1;
                    if (XL == 0) exp_conv = msum; else snap_pending = 1'b1;
                end else if (busy > 0) begin
                    busy--;
                end
            end
            dv = acc_p - acc_n;
            chk_cnt++; if (dv !== msum) begin if (errs < 10) $display("FAIL rnd_invariant: cyc %0d got %h want %h", cyc, dv, msum); errs++; end else pass_cnt++;
            chk_cnt++; if (in_ready !== (busy == 0)) begin if (errs < 10) $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, in_ready, busy == 0); errs++; end else pass_cnt++;
            chk_cnt++; if (conv_valid !== (busy == 1)) begin if (errs < 10) $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, conv_valid, busy == 1); errs++; end else pass_cnt++;
            if (busy == 1) begin
                chk_cnt++; if (conv_data !== exp_conv) begin if (errs < 10) $display("FAIL rnd_conv_data: cyc %0d got %h want %h", cyc, conv_data, exp_conv); errs++; end else pass_cnt++;
            end
        end
        in_valid = 1'b0; in_sub = 1'b0; in_data = '0; conv_req = 1'b0; clr = 1'b0;
        chk_cnt++; if (accepted < 2000) $display("FAIL rnd_beats: got %0d want 2000", accepted); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_same_edge();
        test_clr_conv();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
